// File: rtl/ex_muldiv.sv
// ---------------------------------------------------------------------------
// ex_muldiv
//   Iterative RV32M multiply/divide unit for the EX stage. One shift-add
//   (multiply) or restoring shift-subtract (divide) step per cycle on operand
//   magnitudes. The sign is fixed up when the result is written. Divide-by-zero
//   and signed overflow skip the iteration and finish one cycle after start.
//
// Ports
//   clk       rising-edge clock for all state
//   rst       asynchronous, active-high reset
//   start_i   request a new operation (sampled only in IDLE)
//   flush_i   abort the in-flight operation; wins over start_i
//   op_i      RV32M funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   rs1_i     operand A (multiplicand / dividend)
//   rs2_i     operand B (multiplier / divisor)
//   busy_o    high while not IDLE (pipeline stall)
//   done_o    one-cycle completion pulse, result_o valid in the same cycle
//   result_o  registered result, held until the next completion
// ---------------------------------------------------------------------------
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;   // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0] hi_q;     // product high half (mul) or partial remainder (div)
  logic [XLEN-1:0] lo_q;     // multiplier shifting out / quotient shifting in
  logic            neg_q;    // final result must be negated
  logic [5:0]      cnt_q;

  // Operand decode at accept time
  logic            sign_a;
  logic            sign_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            neg_in;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    sign_a   = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
               (op_i == OP_DIV)  || (op_i == OP_REM);
    sign_b   = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg    = sign_a & rs1_i[XLEN-1];
    b_neg    = sign_b & rs2_i[XLEN-1];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
    // Remainder follows the dividend; product and quotient follow sign XOR.
    neg_in   = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = op_i[2] && (rs2_i == '0);
    div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
               (rs1_i == MIN_INT) && (rs2_i == '1);
    if (div_zero) begin
      fast_res = op_i[1] ? rs1_i : '1;
    end else begin
      fast_res = (op_i == OP_DIV) ? MIN_INT : '0;
    end
  end

  // One iteration step and the sign-corrected result built from its outcome
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   lo_nxt;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      // Borrow means the divisor did not fit: keep the shifted remainder.
      hi_nxt = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      lo_nxt = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    prod   = {hi_nxt, lo_nxt};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -lo_nxt : lo_nxt;
    rem_s  = neg_q ? -hi_nxt : hi_nxt;

    unique case (op_q)
      OP_MUL:                        final_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = quo_s;
      OP_REM, OP_REMU:               final_res = rem_s;
      default:                       final_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            op_q   <= op_i;
            neg_q  <= neg_in;
            cnt_q  <= '0;
            hi_q   <= '0;
            opnd_q <= op_i[2] ? b_mag : a_mag;
            lo_q   <= op_i[2] ? a_mag : b_mag;
            if (div_zero || div_ovf) begin
              result_o <= fast_res;
              state    <= DONE;
            end else begin
              state    <= CALC;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state <= IDLE;
          end else begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LAST_CNT) begin
              result_o <= final_res;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_ex_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv
//   Self-checking bench for ex_muldiv (XLEN = 32). Expected results are pushed
//   onto a scoreboard queue when an operation is started and popped when
//   done_o rises; result, latency and busy behaviour are compared.
// ---------------------------------------------------------------------------
module tb_ex_muldiv;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic            flush_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] lastResult = '0;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%08h, required 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference behaviour written from the RV32M definitions
  function automatic logic [31:0] modelResult(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] p;
    int          sa;
    int          sb;
    longint      la;
    longint      lb;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    la = longint'(sa);
    lb = longint'(sb);
    r  = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = la * lb; r = p[63:32]; end
      3'd2: begin p = la * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(sa / sb);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = 32'(sa % sb);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int modelLatency(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Entered at the negedge of cycle startCyc after the accept edge; waits for
  // done_o, then pops the scoreboard and compares.
  task automatic waitDone(input int startCyc);
    int   cyc;
    logic busyOk;
    exp_t got;
    cyc    = startCyc;
    busyOk = 1'b1;
    while (done_o !== 1'b1 && cyc < 200) begin
      if (busy_o !== 1'b1) busyOk = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (busy_o !== 1'b1) busyOk = 1'b0;
    got = sbQ.pop_front();
    if (done_o !== 1'b1) begin
      checkOutput({got.tag, "_timeout"}, 32'(done_o), 32'd1);
    end else begin
      checkOutput({got.tag, "_result"}, result_o, got.res);
      checkOutput({got.tag, "_latency"}, 32'(cyc), 32'(got.lat));
      checkOutput({got.tag, "_busy"}, 32'(busyOk), 32'd1);
      lastResult = got.res;
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at a negedge in IDLE.
  task automatic applyStimulus(input string tag, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes);
    exp_t e;
    e.tag = tag;
    e.res = expRes;
    e.lat = modelLatency(op, a, b);
    sbQ.push_back(e);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    @(negedge clk);
    start_i = 1'b0;
    waitDone(1);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {30'b0, busy_o, done_o}, 32'd0);
  endtask

  initial begin
    bit   sawDone;
    exp_t e;

    rst     = 1'b1;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_result", result_o, 32'd0);
    rst = 1'b0;

    // Multiply corner cases
    applyStimulus("mul_ff",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    applyStimulus("mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyStimulus("mulh_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    applyStimulus("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
    applyStimulus("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    applyStimulus("mul_x16",   3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);

    // Divide, signed and unsigned
    applyStimulus("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    applyStimulus("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    applyStimulus("divu_7_2",  3'd5, 32'd7, 32'd2, 32'd3);
    applyStimulus("remu_7_2",  3'd7, 32'd7, 32'd2, 32'd1);
    applyStimulus("div_7_m2",  3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    applyStimulus("rem_7_m2",  3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1);
    applyStimulus("divu_max",  3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    applyStimulus("div_min_1", 3'd4, 32'h8000_0000, 32'd1, 32'h8000_0000);

    // Fast paths: divide by zero and signed overflow
    applyStimulus("divu_z",    3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF);
    applyStimulus("remu_z",    3'd7, 32'd100, 32'd0, 32'd100);
    applyStimulus("div_z",     3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF);
    applyStimulus("rem_z",     3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    applyStimulus("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    applyStimulus("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Random operations against the reference model
    for (int i = 0; i < 16; i++) begin
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 20));
        1:       rb = 32'd0;
        default: rb = $urandom;
      endcase
      applyStimulus($sformatf("rnd%0d", i), rop, ra, rb, modelResult(rop, ra, rb));
    end

    // Flush at CALC cycle 10: back to IDLE, no done, result untouched
    start_i = 1'b1;
    op_i    = 3'd5;
    rs1_i   = 32'd1000;
    rs2_i   = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    sawDone = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (done_o === 1'b1) sawDone = 1'b1;
      @(negedge clk);
    end
    if (done_o === 1'b1) sawDone = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_busy", 32'(busy_o), 32'd0);
    checkOutput("flush_nodone", 32'({sawDone, done_o}), 32'd0);
    checkOutput("flush_result", result_o, lastResult);
    applyStimulus("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333);

    // start_i held high: operands frozen in CALC, one accept per IDLE visit
    e.tag = "hold_mul";
    e.res = 32'd15;
    e.lat = XLEN + 1;
    sbQ.push_back(e);
    start_i = 1'b1;
    op_i    = 3'd0;
    rs1_i   = 32'd3;
    rs2_i   = 32'd5;
    repeat (5) @(negedge clk);
    op_i    = 3'd5;
    rs1_i   = 32'd100;
    rs2_i   = 32'd7;
    waitDone(5);
    @(negedge clk);
    checkOutput("hold_idle_visit", 32'(busy_o), 32'd0);
    @(negedge clk);
    checkOutput("hold_reaccept", 32'(busy_o), 32'd1);
    repeat (5) @(negedge clk);

    // Reset mid-CALC with start still held
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_done", 32'(done_o), 32'd0);
    checkOutput("midrst_result", result_o, 32'd0);
    @(negedge clk);
    checkOutput("midrst_hold", {30'b0, busy_o, done_o}, 32'd0);
    e.tag = "post_rst";
    e.res = 32'd14;
    e.lat = XLEN + 1;
    sbQ.push_back(e);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_accept", 32'(busy_o), 32'd1);
    waitDone(1);
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", {30'b0, busy_o, done_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
